// File: rtl/cnn_target_ctrl.sv
// cnn_target_ctrl: filters CNN detections by class and score, smooths the box
// centre into target_x/target_y and runs the IDLE/ACQ/TRACK/LOCKED/LOST machine.
module cnn_target_ctrl #(
  parameter int         H_MAX       = 639,
  parameter int         V_MAX       = 479,
  parameter logic [7:0] SCORE_TH    = 8'd128,
  parameter int         ALPHA_SHIFT = 2,
  parameter int         ACQ_HITS    = 2,
  parameter int         LOCK_TOL    = 8,
  parameter int         LOCK_CNT    = 4,
  parameter int         TIMEOUT     = 50_000_000,
  parameter int         LOST_HOLD   = 100_000_000
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       det_valid,
  output logic       det_ready,
  input  logic [3:0] det_class,
  input  logic [7:0] det_score,
  input  logic [9:0] det_x,
  input  logic [9:0] det_y,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic [2:0] msg_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACQ    = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    LOST   = 3'd4
  } state_t;

  localparam int TO_W   = $clog2(TIMEOUT);
  localparam int HOLD_W = $clog2(LOST_HOLD);
  localparam int HIT_W  = $clog2(ACQ_HITS + 1);
  localparam int LCK_W  = $clog2(LOCK_CNT + 1);

  localparam logic [9:0]        X_MAX     = 10'(H_MAX);
  localparam logic [9:0]        Y_MAX     = 10'(V_MAX);
  localparam logic [9:0]        X_CTR     = 10'((H_MAX + 1) / 2);
  localparam logic [9:0]        Y_CTR     = 10'((V_MAX + 1) / 2);
  localparam logic [9:0]        TOL       = 10'(LOCK_TOL);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOST_HOLD - 1);
  localparam logic [HIT_W-1:0]  HIT_MAX   = HIT_W'(ACQ_HITS);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(ACQ_HITS - 1);
  localparam logic [LCK_W-1:0]  LCK_MAX   = LCK_W'(LOCK_CNT);
  localparam logic [LCK_W-1:0]  LCK_LAST  = LCK_W'(LOCK_CNT - 1);

  state_t              state, state_next;
  logic                s1_valid, s1_qual;
  logic [9:0]          s1_x, s1_y;
  logic [TO_W-1:0]     to_cnt, to_cnt_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
  logic [HIT_W-1:0]    hit_cnt, hit_cnt_next;
  logic [LCK_W-1:0]    lock_cnt, lock_cnt_next;
  logic [9:0]          tx_next, ty_next, sm_x, sm_y;
  logic                hit, timeout, hold_exp, on;

  // Move tgt toward det by diff>>>ALPHA_SHIFT (floor), then clamp to [0,maxv].
  function automatic logic [9:0] smooth(input logic [9:0] tgt, input logic [9:0] det,
                                        input logic [9:0] maxv);
    logic signed [10:0] diff;
    logic signed [10:0] sh;
    logic signed [11:0] sum;
    diff = $signed({1'b0, det}) - $signed({1'b0, tgt});
    sh   = diff >>> ALPHA_SHIFT;
    sum  = $signed({2'b00, tgt}) + $signed({sh[10], sh});
    if (sum < 0)                          smooth = 10'd0;
    else if (sum > $signed({2'b00, maxv})) smooth = maxv;
    else                                  smooth = sum[9:0];
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    absdiff = (a > b) ? (a - b) : (b - a);
  endfunction

  assign det_ready = !s1_valid;
  assign msg_code  = state;
  assign hit       = s1_valid && s1_qual;
  assign timeout   = (to_cnt == TO_LAST);
  assign hold_exp  = (state == LOST) && (hold_cnt == HOLD_LAST);
  assign sm_x      = smooth(target_x, s1_x, X_MAX);
  assign sm_y      = smooth(target_y, s1_y, Y_MAX);
  assign on        = (absdiff(cur_x, sm_x) <= TOL) && (absdiff(cur_y, sm_y) <= TOL);

  // Stage 1: capture an accepted detection (clamped) for processing next cycle.
  always_ff @(posedge clk100) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_qual  <= 1'b0;
      s1_x     <= 10'd0;
      s1_y     <= 10'd0;
    end else if (det_valid && det_ready) begin
      s1_valid <= 1'b1;
      s1_qual  <= (det_class != 4'd0) && (det_score >= SCORE_TH);
      s1_x     <= (det_x > X_MAX) ? X_MAX : det_x;
      s1_y     <= (det_y > Y_MAX) ? Y_MAX : det_y;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // State register; msg_code is this register's encoding.
  always_ff @(posedge clk100) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a qualified hit takes priority over timeout or hold expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit) state_next = ACQ;
      ACQ:     if (hit) begin
                 if (hit_cnt >= HIT_LAST) state_next = TRACK;
               end else if (timeout) state_next = IDLE;
      TRACK:   if (hit) begin
                 if (on && lock_cnt == LCK_LAST) state_next = LOCKED;
               end else if (timeout) state_next = LOST;
      LOCKED:  if (hit) begin
                 if (!on) state_next = TRACK;
               end else if (timeout) state_next = LOST;
      LOST:    if (hit) state_next = ACQ;
               else if (hold_exp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the target registers and the hit/lock/timeout/hold counters.
  always_comb begin
    tx_next       = target_x;
    ty_next       = target_y;
    hit_cnt_next  = hit_cnt;
    lock_cnt_next = lock_cnt;
    if (state == IDLE || state == LOST || hit) to_cnt_next = '0;
    else if (to_cnt != TO_LAST)                to_cnt_next = to_cnt + 1'b1;
    else                                       to_cnt_next = to_cnt;
    if (state != LOST || hit)                  hold_cnt_next = '0;
    else if (hold_cnt != HOLD_LAST)            hold_cnt_next = hold_cnt + 1'b1;
    else                                       hold_cnt_next = hold_cnt;
    case (state)
      IDLE, LOST: begin
        lock_cnt_next = '0;
        if (hit) begin
          tx_next      = s1_x;
          ty_next      = s1_y;
          hit_cnt_next = HIT_W'(1);
        end else if (hold_exp) begin
          tx_next = X_CTR;
          ty_next = Y_CTR;
        end
      end
      ACQ: begin
        lock_cnt_next = '0;
        if (hit) begin
          tx_next      = sm_x;
          ty_next      = sm_y;
          hit_cnt_next = (hit_cnt == HIT_MAX) ? hit_cnt : hit_cnt + 1'b1;
        end else if (timeout) begin
          tx_next = X_CTR;
          ty_next = Y_CTR;
        end
      end
      TRACK, LOCKED: begin
        if (hit) begin
          tx_next = sm_x;
          ty_next = sm_y;
          if (!on)                   lock_cnt_next = '0;
          else if (lock_cnt != LCK_MAX) lock_cnt_next = lock_cnt + 1'b1;
        end
      end
      default: begin
        tx_next = X_CTR;
        ty_next = Y_CTR;
      end
    endcase
  end

  // Target and counter registers.
  always_ff @(posedge clk100) begin
    if (rst) begin
      target_x <= X_CTR;
      target_y <= Y_CTR;
      to_cnt   <= '0;
      hold_cnt <= '0;
      hit_cnt  <= '0;
      lock_cnt <= '0;
    end else begin
      target_x <= tx_next;
      target_y <= ty_next;
      to_cnt   <= to_cnt_next;
      hold_cnt <= hold_cnt_next;
      hit_cnt  <= hit_cnt_next;
      lock_cnt <= lock_cnt_next;
    end
  end

endmodule

// File: tb/tb_cnn_target_ctrl.sv
// tb_cnn_target_ctrl: directed checks of cnn_target_ctrl with short timeouts.
module tb_cnn_target_ctrl;

  logic       clk100 = 1'b0;
  logic       rst, det_valid, det_ready;
  logic [3:0] det_class;
  logic [7:0] det_score;
  logic [9:0] det_x, det_y, cur_x, cur_y, target_x, target_y;
  logic [2:0] msg_code;
  int         checkCount = 0;
  int         passCount  = 0;
  int         cyc        = 0;
  int         e0;

  cnn_target_ctrl #(.TIMEOUT(100), .LOST_HOLD(50)) dut (
    .clk100(clk100), .rst(rst), .det_valid(det_valid), .det_ready(det_ready),
    .det_class(det_class), .det_score(det_score), .det_x(det_x), .det_y(det_y),
    .cur_x(cur_x), .cur_y(cur_y), .target_x(target_x), .target_y(target_y),
    .msg_code(msg_code)
  );

  // 100 MHz clock.
  always #5 clk100 = ~clk100;

  // Edge counter used to time the timeout and hold checks.
  always @(posedge clk100) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic checkOutput(input string tag, input int tx, input int ty, input int msg);
    checkValue({tag, " target_x"}, 32'(target_x), tx);
    checkValue({tag, " target_y"}, 32'(target_y), ty);
    checkValue({tag, " msg_code"}, 32'(msg_code), msg);
  endtask

  task automatic applyStimulus(input logic [3:0] cls, input logic [7:0] sc,
                               input logic [9:0] x, input logic [9:0] y);
    int guard = 0;
    @(negedge clk100);
    while (!det_ready && guard < 20) begin
      @(negedge clk100);
      guard++;
    end
    checkValue("det_ready before send", 32'(det_ready), 1);
    det_class = cls;
    det_score = sc;
    det_x     = x;
    det_y     = y;
    det_valid = 1'b1;
    @(posedge clk100);
    #1 det_valid = 1'b0;
    @(posedge clk100);
    #1;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; det_valid = 1'b0; det_class = '0; det_score = '0;
    det_x = '0; det_y = '0; cur_x = '0; cur_y = '0;
    repeat (2) @(posedge clk100);
    #1 rst = 1'b0;
    checkOutput("reset", 320, 240, 0);
    checkValue("reset det_ready", 32'(det_ready), 1);

    applyStimulus(4'd3, 8'd200, 10'd100, 10'd50);
    checkOutput("first load", 100, 50, 1);
    applyStimulus(4'd3, 8'd200, 10'd200, 10'd50);
    checkOutput("acq smooth", 125, 50, 2);

    cur_x = 10'd125; cur_y = 10'd50;
    applyStimulus(4'd3, 8'd200, 10'd125, 10'd50);
    applyStimulus(4'd3, 8'd200, 10'd125, 10'd50);
    applyStimulus(4'd3, 8'd200, 10'd125, 10'd50);
    checkOutput("three on-target", 125, 50, 2);
    applyStimulus(4'd3, 8'd200, 10'd125, 10'd50);
    checkOutput("lock", 125, 50, 3);
    cur_x = 10'd145;
    applyStimulus(4'd3, 8'd200, 10'd125, 10'd50);
    checkOutput("lock lost", 125, 50, 2);
    e0 = cyc;
    cur_x = '0; cur_y = '0;

    applyStimulus(4'd3, 8'd127, 10'd400, 10'd400);
    checkOutput("score 127 dropped", 125, 50, 2);
    applyStimulus(4'd0, 8'd200, 10'd400, 10'd400);
    checkOutput("class 0 dropped", 125, 50, 2);
    waitCycle(e0 + 99);
    checkValue("pre-timeout msg_code", 32'(msg_code), 2);
    @(posedge clk100); #1;
    checkOutput("timeout", 125, 50, 4);
    waitCycle(e0 + 149);
    checkOutput("lost hold", 125, 50, 4);
    @(posedge clk100); #1;
    checkOutput("hold expiry", 320, 240, 0);

    applyStimulus(4'd2, 8'd150, 10'd10, 10'd100);
    checkOutput("load x10", 10, 100, 1);
    applyStimulus(4'd2, 8'd150, 10'd0, 10'd100);
    checkOutput("floor shift", 7, 100, 2);
    applyStimulus(4'd2, 8'd128, 10'd700, 10'd600);
    checkOutput("clamp", 165, 194, 2);

    @(negedge clk100);
    det_class = 4'd2; det_score = 8'd200; det_x = 10'd205; det_y = 10'd194;
    det_valid = 1'b1;
    @(posedge clk100); #1;
    checkValue("held valid ready 0a", 32'(det_ready), 0);
    checkValue("held valid tx 0a", 32'(target_x), 165);
    @(posedge clk100); #1;
    checkValue("held valid ready 1a", 32'(det_ready), 1);
    checkValue("held valid tx 1a", 32'(target_x), 175);
    @(posedge clk100); #1;
    checkValue("held valid ready 0b", 32'(det_ready), 0);
    checkValue("held valid tx 0b", 32'(target_x), 175);
    @(posedge clk100); #1;
    checkValue("held valid ready 1b", 32'(det_ready), 1);
    checkValue("held valid tx 1b", 32'(target_x), 182);
    det_valid = 1'b0;
    e0 = cyc;

    waitCycle(e0 + 99);
    checkValue("second pre-timeout msg_code", 32'(msg_code), 2);
    @(posedge clk100); #1;
    checkOutput("second timeout", 182, 194, 4);
    applyStimulus(4'd1, 8'd255, 10'd300, 10'd200);
    checkOutput("lost reacquire", 300, 200, 1);
    applyStimulus(4'd1, 8'd255, 10'd300, 10'd200);
    checkOutput("back to track", 300, 200, 2);

    @(negedge clk100);
    rst = 1'b1;
    @(posedge clk100); #1;
    checkOutput("mid-track reset", 320, 240, 0);
    checkValue("mid-track reset det_ready", 32'(det_ready), 1);
    @(posedge clk100); #1;
    rst = 1'b0;
    applyStimulus(4'd3, 8'd200, 10'd100, 10'd50);
    checkOutput("post-reset load", 100, 50, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
